// File: rtl/memory_access_unit_if.sv
// Data-memory bus between memory_access_unit (master) and the memory (slave).
//
// Handshake: mem_req is the valid. Once mem_req rises, mem_we, mem_addr,
// mem_wdata and mem_byte_en stay stable until the memory answers with
// mem_ready. The transfer completes on the rising edge where mem_req and
// mem_ready are both high; mem_rdata is only meaningful on that edge.
interface memory_access_unit_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
);
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDRESS_BITS-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [3:0]              mem_byte_en;
  logic                    mem_ready;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/memory_access_unit.sv
// Memory pipeline stage in front of writeback: runs one load/store per
// instruction over the memory_access_unit_if bus, aligns and extends load
// data, and registers the writeback bundle.
// Optional build macro: MEMORY_ACCESS_UNIT_REPORT_EN adds a cycle counter
// and a per-cycle $display trace gated by the report input.
module memory_access_unit #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    load,
  input  logic                    store,
  input  logic [2:0]              funct3,
  input  logic [ADDRESS_BITS-1:0] address,
  input  logic [DATA_WIDTH-1:0]   store_data,
  input  logic                    opWrite_in,
  input  logic                    opSel_in,
  input  logic [4:0]              opReg_in,
  input  logic [DATA_WIDTH-1:0]   ALU_Result_in,
  memory_access_unit_if.master    mem,
  output logic                    opWrite,
  output logic                    opSel,
  output logic [4:0]              opReg,
  output logic [DATA_WIDTH-1:0]   ALU_Result,
  output logic [DATA_WIDTH-1:0]   memory_data,
  output logic                    busy,
  output logic                    misaligned,
  output logic [1:0]              state_dbg,
  input  logic                    report
);

  // Encoding is visible on state_dbg: 0 IDLE, 1 ACCESS, 2 DONE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Held request and writeback fields for the in-flight access
  logic                    mem_req_q, mem_we_q;
  logic [ADDRESS_BITS-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [3:0]              mem_be_q;
  logic [2:0]              funct3_q;
  logic [1:0]              off_q;
  logic                    store_q;
  logic                    hold_opwrite, hold_opsel;
  logic [4:0]              hold_opreg;
  logic [DATA_WIDTH-1:0]   hold_alu;
  logic [DATA_WIDTH-1:0]   buf_q;

  // Request decode
  logic                  is_mem_op, is_byte, is_half, aligned;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [3:0]            be_next;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] load_data, access_data;

  assign is_mem_op = load | store;
  assign is_byte   = (funct3 == 3'b000) || (funct3 == 3'b100);
  assign is_half   = (funct3 == 3'b001) || (funct3 == 3'b101);
  // Anything that is not B/H is a word access, including undefined funct3
  assign aligned   = is_byte ||
                     (is_half && !address[0]) ||
                     (!is_byte && !is_half && (address[1:0] == 2'b00));

  assign mem.mem_req     = mem_req_q;
  assign mem.mem_we      = mem_we_q;
  assign mem.mem_addr    = mem_addr_q;
  assign mem.mem_wdata   = mem_wdata_q;
  assign mem.mem_byte_en = mem_be_q;

  // Store lane replication and byte enables for the presented request
  always_comb begin
    wdata_next = store_data;
    be_next    = 4'b1111;
    if (is_byte) begin
      wdata_next = {(DATA_WIDTH/8){store_data[7:0]}};
      be_next    = 4'b0001 << address[1:0];
    end else if (is_half) begin
      wdata_next = {(DATA_WIDTH/16){store_data[15:0]}};
      be_next    = 4'b0011 << {address[1], 1'b0};
    end
  end

  // Load lane selection and sign/zero extension of the memory response
  always_comb begin
    case (off_q)
      2'd1:    rd_byte = mem.mem_rdata[15:8];
      2'd2:    rd_byte = mem.mem_rdata[23:16];
      2'd3:    rd_byte = mem.mem_rdata[31:24];
      default: rd_byte = mem.mem_rdata[7:0];
    endcase
    rd_half = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{(DATA_WIDTH-8){rd_byte[7]}}, rd_byte};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, rd_byte};
      3'b001:  load_data = {{(DATA_WIDTH-16){rd_half[15]}}, rd_half};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, rd_half};
      default: load_data = mem.mem_rdata;
    endcase
    access_data = store_q ? '0 : load_data;
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!stall && is_mem_op && aligned) state_d = ACCESS;
      ACCESS:  if (mem.mem_ready) state_d = stall ? DONE : IDLE;
      DONE:    if (!stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: upstream hold request and state visibility
  always_comb begin
    busy      = ((state_q == IDLE) && is_mem_op && !stall && aligned) ||
                ((state_q == ACCESS) && !(mem.mem_ready && !stall));
    state_dbg = state_q;
  end

  // Request latching, writeback bundle, buffering and the misaligned pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      funct3_q     <= '0;
      off_q        <= '0;
      store_q      <= 1'b0;
      hold_opwrite <= 1'b0;
      hold_opsel   <= 1'b0;
      hold_opreg   <= '0;
      hold_alu     <= '0;
      buf_q        <= '0;
      opWrite      <= 1'b0;
      opSel        <= 1'b0;
      opReg        <= '0;
      ALU_Result   <= '0;
      memory_data  <= '0;
      misaligned   <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!stall) begin
            if (!is_mem_op) begin
              opWrite     <= opWrite_in;
              opSel       <= opSel_in;
              opReg       <= opReg_in;
              ALU_Result  <= ALU_Result_in;
              memory_data <= '0;
            end else if (aligned) begin
              mem_req_q    <= 1'b1;
              mem_we_q     <= store;
              mem_addr_q   <= {address[ADDRESS_BITS-1:2], 2'b00};
              mem_wdata_q  <= wdata_next;
              mem_be_q     <= be_next;
              funct3_q     <= funct3;
              off_q        <= address[1:0];
              store_q      <= store;
              hold_opwrite <= opWrite_in;
              hold_opsel   <= opSel_in;
              hold_opreg   <= opReg_in;
              hold_alu     <= ALU_Result_in;
              opWrite      <= 1'b0;
            end else begin
              opWrite    <= 1'b0;
              misaligned <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (mem.mem_ready) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (!stall) begin
              opWrite     <= hold_opwrite;
              opSel       <= hold_opsel;
              opReg       <= hold_opreg;
              ALU_Result  <= hold_alu;
              memory_data <= access_data;
            end else begin
              buf_q <= access_data;
            end
          end
        end
        DONE: begin
          if (!stall) begin
            opWrite     <= hold_opwrite;
            opSel       <= hold_opsel;
            opReg       <= hold_opreg;
            ALU_Result  <= hold_alu;
            memory_data <= buf_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEMORY_ACCESS_UNIT_REPORT_EN
  logic [31:0] cycle_q;

  // Free-running cycle counter for the trace
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle_q <= '0;
    else        cycle_q <= cycle_q + 32'd1;
  end

  // Per-cycle trace while report is enabled
  always_ff @(posedge clock) begin
    if (report) begin
      $display("[core %0d cyc %0d] st=%0d req=%b we=%b addr=%h wd=%h be=%b rdy=%b | opW=%b opS=%b rd=%0d alu=%h md=%h",
               CORE, cycle_q, state_q, mem_req_q, mem_we_q, mem_addr_q, mem_wdata_q,
               mem_be_q, mem.mem_ready, opWrite, opSel, opReg, ALU_Result, memory_data);
    end
  end
`else
  logic unused_report;
  localparam int unused_core = CORE;
  assign unused_report = report;
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: directed cases followed by randomized
// transactions, checked against an arithmetic reference of the load/store
// rules and a model of the writeback bundle.
module tb_memory_access_unit;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic          clock = 1'b0;
  logic          reset;
  logic          stall, load, store;
  logic [2:0]    funct3;
  logic [AW-1:0] address;
  logic [DW-1:0] store_data;
  logic          opWrite_in, opSel_in;
  logic [4:0]    opReg_in;
  logic [DW-1:0] ALU_Result_in;
  logic          opWrite, opSel;
  logic [4:0]    opReg;
  logic [DW-1:0] ALU_Result, memory_data;
  logic          busy, misaligned;
  logic [1:0]    state_dbg;
  logic          report;

  memory_access_unit_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW)) mem_bus ();

  memory_access_unit #(.CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW)) dut (
    .clock(clock), .reset(reset), .stall(stall), .load(load), .store(store),
    .funct3(funct3), .address(address), .store_data(store_data),
    .opWrite_in(opWrite_in), .opSel_in(opSel_in), .opReg_in(opReg_in),
    .ALU_Result_in(ALU_Result_in), .mem(mem_bus),
    .opWrite(opWrite), .opSel(opSel), .opReg(opReg), .ALU_Result(ALU_Result),
    .memory_data(memory_data), .busy(busy), .misaligned(misaligned),
    .state_dbg(state_dbg), .report(report)
  );

  // Clock
  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model of the committed writeback bundle
  logic          exp_opw, exp_ops;
  logic [4:0]    exp_opr;
  logic [DW-1:0] exp_alu, exp_md;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_opWrite"},    32'(opWrite),    32'(exp_opw));
    check({tag, "_opSel"},      32'(opSel),      32'(exp_ops));
    check({tag, "_opReg"},      32'(opReg),      32'(exp_opr));
    check({tag, "_ALU_Result"}, ALU_Result,      exp_alu);
    check({tag, "_memory_data"}, memory_data,    exp_md);
  endtask

  // Access size in bytes from funct3; unknown codes are words
  function automatic int unsigned size_of(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [AW-1:0] addr,
                                           input logic [31:0] rdata);
    int unsigned sz;
    longint v;
    sz = size_of(f3);
    v  = longint'(rdata >> ((addr % 4) * 8));
    if (sz == 1) begin
      v = v % 256;
      if (f3 == 3'b000 && v >= 128) v = v - 256;
    end else if (sz == 2) begin
      v = v % 65536;
      if (f3 == 3'b001 && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int unsigned sz;
    sz = size_of(f3);
    if (sz == 1) return (sd % 256) * 32'h0101_0101;
    if (sz == 2) return (sd % 65536) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [AW-1:0] addr);
    int unsigned sz;
    sz = size_of(f3);
    return 4'(((1 << sz) - 1) << (addr % 4));
  endfunction

  // One instruction through the stage; leaves the unit idle with stall high
  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3, input logic [AW-1:0] addr,
                       input logic [31:0] sd, input logic [31:0] rdata, input int waits,
                       input int stalls_after, input int pre_stall, input bit opw, input bit ops,
                       input logic [4:0] opr, input logic [31:0] alu);
    bit is_mem, mis;
    logic [31:0] exp_data;
    logic [AW-1:0] exp_addr;
    is_mem   = ld | st;
    mis      = is_mem && ((addr % size_of(f3)) != 0);
    exp_addr = addr - AW'(addr % 4);
    load = ld; store = st; funct3 = f3; address = addr; store_data = sd;
    opWrite_in = opw; opSel_in = ops; opReg_in = opr; ALU_Result_in = alu;
    stall = 1'b1;
    for (int i = 0; i < pre_stall; i++) begin
      mem_bus.mem_ready = 1'($urandom);
      #1;
      check("stall_idle_busy", 32'(busy), 32'd0);
      @(posedge clock); #1;
      check("stall_idle_state", 32'(state_dbg), 32'(S_IDLE));
      check("stall_idle_req", 32'(mem_bus.mem_req), 32'd0);
      check_outs("stall_idle");
    end
    mem_bus.mem_ready = 1'b0;
    stall = 1'b0;
    #1;
    check("accept_busy", 32'(busy), 32'(is_mem && !mis));
    @(posedge clock); #1;
    if (!is_mem) begin
      exp_opw = opw; exp_ops = ops; exp_opr = opr; exp_alu = alu; exp_md = '0;
      check_outs("nop");
      check("nop_state", 32'(state_dbg), 32'(S_IDLE));
    end else if (mis) begin
      exp_opw = 1'b0;
      check("mis_pulse", 32'(misaligned), 32'd1);
      check("mis_req", 32'(mem_bus.mem_req), 32'd0);
      check("mis_state", 32'(state_dbg), 32'(S_IDLE));
      check("mis_busy", 32'(busy), 32'd0);
      check_outs("mis");
      stall = 1'b1; load = 1'b0; store = 1'b0;
      @(posedge clock); #1;
      check("mis_pulse_end", 32'(misaligned), 32'd0);
      check_outs("mis_after");
    end else begin
      exp_opw = 1'b0;
      check("acc_state", 32'(state_dbg), 32'(S_ACCESS));
      check("acc_req", 32'(mem_bus.mem_req), 32'd1);
      check("acc_we", 32'(mem_bus.mem_we), 32'(st));
      check("acc_addr", 32'(mem_bus.mem_addr), 32'(exp_addr));
      if (st) begin
        check("acc_wdata", mem_bus.mem_wdata, ref_wdata(f3, sd));
        check("acc_be", 32'(mem_bus.mem_byte_en), 32'(ref_be(f3, addr)));
      end
      check_outs("acc");
      for (int w = 0; w < waits; w++) begin
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = $urandom;
        #1;
        check("wait_busy", 32'(busy), 32'd1);
        @(posedge clock); #1;
        check("wait_state", 32'(state_dbg), 32'(S_ACCESS));
        check("wait_req", 32'(mem_bus.mem_req), 32'd1);
        check("wait_addr", 32'(mem_bus.mem_addr), 32'(exp_addr));
        check_outs("wait");
      end
      mem_bus.mem_ready = 1'b1;
      mem_bus.mem_rdata = rdata;
      stall = (stalls_after > 0);
      #1;
      check("ready_busy", 32'(busy), 32'(stalls_after > 0));
      @(posedge clock); #1;
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = $urandom;
      check("ready_req_drop", 32'(mem_bus.mem_req), 32'd0);
      exp_data = st ? 32'd0 : ref_load(f3, addr, rdata);
      if (stalls_after > 0) begin
        check("done_state", 32'(state_dbg), 32'(S_DONE));
        check("done_busy", 32'(busy), 32'd0);
        check_outs("done_frozen");
        for (int s = 1; s < stalls_after; s++) begin
          @(posedge clock); #1;
          check("done_hold_state", 32'(state_dbg), 32'(S_DONE));
          check_outs("done_hold");
        end
        stall = 1'b0;
        @(posedge clock); #1;
      end
      exp_opw = opw; exp_ops = ops; exp_opr = opr; exp_alu = alu; exp_md = exp_data;
      check_outs("commit");
      check("commit_state", 32'(state_dbg), 32'(S_IDLE));
    end
    load = 1'b0; store = 1'b0; stall = 1'b1;
  endtask

  // Abort a load from ACCESS or from DONE with an asynchronous reset
  task automatic reset_mid(input bit in_done);
    load = 1'b1; store = 1'b0; funct3 = 3'b010; address = 20'h00400; store_data = '0;
    opWrite_in = 1'b1; opSel_in = 1'b1; opReg_in = 5'd9; ALU_Result_in = 32'h0000_0400;
    stall = 1'b0;
    @(posedge clock); #1;
    load = 1'b0; stall = 1'b1;
    if (in_done) begin
      mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'h5555_AAAA;
      @(posedge clock); #1;
      mem_bus.mem_ready = 1'b0;
    end
    check("rst_pre_state", 32'(state_dbg), in_done ? 32'(S_DONE) : 32'(S_ACCESS));
    #2 reset = 1'b0;
    #1;
    exp_opw = 1'b0; exp_ops = 1'b0; exp_opr = '0; exp_alu = '0; exp_md = '0;
    check("rst_req_async", 32'(mem_bus.mem_req), 32'd0);
    check("rst_we", 32'(mem_bus.mem_we), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    check("rst_misaligned", 32'(misaligned), 32'd0);
    check_outs("rst");
    @(posedge clock); #2;
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst_release_state", 32'(state_dbg), 32'(S_IDLE));
    check("rst_release_busy", 32'(busy), 32'd0);
    check_outs("rst_release");
  endtask

  initial begin
    reset = 1'b0; stall = 1'b1; load = 1'b0; store = 1'b0; funct3 = '0; address = '0;
    store_data = '0; opWrite_in = 1'b0; opSel_in = 1'b0; opReg_in = '0; ALU_Result_in = '0;
    report = 1'b0; mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = '0;
    exp_opw = 1'b0; exp_ops = 1'b0; exp_opr = '0; exp_alu = '0; exp_md = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", 32'(state_dbg), 32'(S_IDLE));
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_req", 32'(mem_bus.mem_req), 32'd0);
    check("reset_we", 32'(mem_bus.mem_we), 32'd0);
    check("reset_addr", 32'(mem_bus.mem_addr), 32'd0);
    check("reset_wdata", mem_bus.mem_wdata, 32'd0);
    check("reset_be", 32'(mem_bus.mem_byte_en), 32'd0);
    check("reset_misaligned", 32'(misaligned), 32'd0);
    check_outs("reset");
    reset = 1'b1;
    @(posedge clock); #1;

    // Directed cases
    do_op(0, 0, 3'b000, 20'h00010, 32'h0, 32'h0, 0, 0, 1, 1, 1, 5'd7, 32'h1234_5678);
    do_op(1, 0, 3'b000, 20'h00103, 32'h0, 32'h8011_2233, 0, 0, 0, 1, 0, 5'd3, 32'h0000_0103);
    check("lb_0x103", memory_data, 32'hFFFF_FF80);
    do_op(1, 0, 3'b100, 20'h00103, 32'h0, 32'h8011_2233, 0, 0, 0, 1, 0, 5'd4, 32'h0000_0103);
    check("lbu_0x103", memory_data, 32'h0000_0080);
    do_op(0, 1, 3'b001, 20'h00102, 32'h0000_ABCD, 32'h0, 0, 0, 0, 0, 0, 5'd0, 32'h0000_0102);
    check("sh_data_zero", memory_data, 32'd0);
    do_op(1, 0, 3'b010, 20'h00200, 32'h0, 32'hDEAD_BEEF, 3, 0, 0, 1, 1, 5'd5, 32'h0000_0200);
    do_op(1, 0, 3'b010, 20'h00300, 32'h0, 32'hCAFE_F00D, 0, 2, 0, 1, 0, 5'd6, 32'h0000_0300);
    check("lw_stalled", memory_data, 32'hCAFE_F00D);
    do_op(1, 0, 3'b010, 20'h00102, 32'h0, 32'h0, 0, 0, 0, 1, 0, 5'd8, 32'h0000_0102);
    do_op(1, 1, 3'b000, 20'h00041, 32'h0000_00A5, 32'hFFFF_FFFF, 1, 0, 0, 0, 1, 5'd2, 32'h41);
    do_op(1, 0, 3'b011, 20'h00020, 32'h0, 32'h1357_9BDF, 0, 0, 0, 1, 0, 5'd1, 32'h20);
    reset_mid(1'b0);
    reset_mid(1'b1);

    // Randomized transactions
    for (int n = 0; n < 80; n++) begin
      bit ld, st;
      int k;
      logic [2:0] f3;
      logic [AW-1:0] a;
      k  = int'($urandom_range(0, 9));
      ld = (k >= 2 && k <= 6) || (k == 9);
      st = (k >= 7);
      if (st) f3 = 3'($urandom_range(0, 2));
      else    f3 = 3'($urandom_range(0, 7));
      a = AW'($urandom_range(0, 20'hFFFFF));
      if ($urandom_range(0, 3) != 0) a = a - AW'(a % size_of(f3));
      do_op(ld, st, f3, a, $urandom, $urandom, int'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0,
            int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), 5'($urandom), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory pipeline stage placed directly upstream of the writeback unit. It runs one data-memory load or store per instruction over a request/ready handshake, and aligns and sign- or zero-extends load data. It registers the writeback control fields (opWrite, opSel, opReg, ALU_Result) alongside memory_data, so writeback sees one coherent bundle. When memory takes longer than one cycle it asserts busy back to the earlier stages, and it buffers a completed access if the downstream stall is high.

## Interface
- CORE, 0, core index used in report output
- DATA_WIDTH, 32, datapath width; only 32 is supported
- ADDRESS_BITS, 20, byte-address width
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  downstream/global stall; freezes committed outputs
- load, store  in  1 each  memory operation request for the presented instruction
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- address  in  ADDRESS_BITS  byte address (ALU result)
- store_data  in  DATA_WIDTH  rs2 value
- opWrite_in, opSel_in  in  1 each; opReg_in  in  5; ALU_Result_in  in  DATA_WIDTH  fields forwarded to writeback
- mem_req, mem_we  out  1 each; mem_addr  out  ADDRESS_BITS (low 2 bits zero); mem_wdata  out  DATA_WIDTH; mem_byte_en  out  4
- mem_ready  in  1; mem_rdata  in  DATA_WIDTH  memory response
- opWrite, opSel  out  1 each; opReg  out  5; ALU_Result, memory_data  out  DATA_WIDTH  registered outputs to writeback
- busy  out  1  combinational; upstream holds its inputs while high
- misaligned  out  1  registered one-cycle pulse on a misaligned access
- report  in  1  debug print enable

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset enters IDLE with every registered output and mem_* output at 0.
- IDLE, stall=1: nothing changes.
- IDLE, stall=0, no memory op: the output registers capture the *_in fields. memory_data is set to 0. Latency is 1 cycle.
- IDLE, stall=0, memory op, aligned:
  - latch mem_addr, mem_we, mem_wdata, mem_byte_en, funct3 and byte offset
  - opWrite is set to 0 (bubble)
  - go to ACCESS
- If load and store are both high, store wins.
- Misaligned access means H with addr[0]=1, or W with addr[1:0]≠0. The unit issues no memory access, sets opWrite to 0, pulses misaligned and stays in IDLE.
- ACCESS: mem_req=1 and all mem_* outputs stay stable until mem_ready=1 is sampled.
  - mem_ready=1 and stall=0: commit. Output registers take the held *_in fields, memory_data takes the aligned load data (0 for a store). mem_req drops; go to IDLE.
  - mem_ready=1 and stall=1: buffer the aligned data internally, drop mem_req, go to DONE.
- DONE: commit the buffered data when stall=0, then go to IDLE.
- busy = (IDLE & (load|store) & !stall & aligned) | (ACCESS & !(mem_ready & !stall)). busy is 0 in DONE.
- Store lanes:
  - SB: mem_wdata={4{b}}, byte_en=0001<<addr[1:0]
  - SH: mem_wdata={2{h}}, byte_en=0011<<{addr[1],1'b0}
  - SW: byte_en=1111
- Load extraction: select the byte or half by address offset. B/H sign-extend; BU/HU zero-extend.
- Undefined funct3 is treated as W.

## Timing
- Zero-wait memory (mem_ready high in the first ACCESS cycle):
  - cycle 0: op presented and accepted
  - cycle 1: ACCESS and commit
  - cycle 2: memory_data valid to writeback
- Each wait cycle adds one cycle of latency.
- Reset asserted mid-ACCESS/DONE aborts the transaction. mem_req falls asynchronously and buffered data is discarded.
- mem_rdata is sampled only in the cycle where mem_ready=1 in ACCESS.
- mem_ready is ignored outside ACCESS.

## Configuration
- MEMORY_ACCESS_UNIT_REPORT_EN defined:
  - compiles in a 32-bit cycle counter, reset to 0
  - on each clock with report=1, $display prints the state, the mem_* signals and the output fields
- Not defined: no counter and no display logic. report is an unused input. Functional behaviour is identical.

## Test plan
- Reset low mid-ACCESS -> mem_req=0 immediately, all outputs 0; after release, FSM in IDLE and busy=0.
- LB at address 0x103, mem_rdata=0x80112233, mem_ready high on first ACCESS cycle -> memory_data=0xFFFFFF80 two cycles after issue; LBU at the same address -> 0x00000080.
- SH at address 0x102, store_data=0x0000ABCD -> mem_we=1, mem_byte_en=1100, mem_wdata=0xABCDABCD, mem_addr=0x100.
- LW with mem_ready delayed 3 cycles -> busy high for 4 cycles, mem_req and mem_addr stable throughout, opWrite=0 until commit.
- LW completes while stall=1 for 2 cycles -> FSM in DONE, outputs frozen; data committed on the first cycle with stall=0.
- LW at address 0x102 -> misaligned pulses for 1 cycle, mem_req stays 0, opWrite=0, busy=0.
